// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state type and sizing defaults for bus_arbiter.
// Contents: state_t (IDLE/OWN/TURN), N_REQ requester count, MAX_HOLD_DEF tenure limit.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  localparam int N_REQ = 4;
  localparam int MAX_HOLD_DEF = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr.
// Ports: req (requests), ptr (highest-priority index), valid (any request), win (winner index).
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] win
);
  // Scan from farthest to nearest offset so the nearest request above ptr wins last.
  always_comb begin
    win = '0;
    for (int i = 3; i >= 0; i--) if (req[ptr + 2'(i)]) win = ptr + 2'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with bounded tenure and one-cycle turnaround.
// Ports: clk, reset (async active-low), req (requests, bit 0 = CPU),
//        gnt (registered one-hot grant), gnt_id (owner index), busy (|gnt), timeout (tenure cut pulse).
module bus_arbiter #(
  parameter int N_REQ    = arb_pkg::N_REQ,
  parameter int MAX_HOLD = arb_pkg::MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             busy,
  output logic             timeout
);
  import arb_pkg::*;
  state_t state, state_nx;
  logic [1:0] ptr, ptr_nx, win, gnt_id_nx;
  logic [4:0] hold_cnt, hold_nx;
  logic [N_REQ-1:0] gnt_nx;
  logic valid, timeout_nx;
  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (valid),
    .win   (win)
  );
  // From IDLE and TURN arbitration is identical; OWN ends on release or when the tenure limit is hit.
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    hold_nx    = hold_cnt;
    gnt_nx     = gnt;
    gnt_id_nx  = gnt_id;
    timeout_nx = 1'b0;
    if (state == OWN) begin
      if (!req[gnt_id] || hold_cnt == 5'(MAX_HOLD - 1)) begin
        state_nx   = TURN;
        ptr_nx     = gnt_id + 2'd1;
        hold_nx    = '0;
        gnt_nx     = '0;
        gnt_id_nx  = '0;
        timeout_nx = req[gnt_id];
      end else begin
        hold_nx = hold_cnt + 5'd1;
      end
    end else begin
      state_nx  = valid ? OWN : IDLE;
      hold_nx   = '0;
      gnt_nx    = valid ? N_REQ'(1) << win : '0;
      gnt_id_nx = valid ? win : 2'd0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      gnt      <= gnt_nx;
      gnt_id   <= gnt_id_nx;
      timeout  <= timeout_nx;
    end
  end
  assign busy = |gnt;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench comparing bus_arbiter against a tenure-level reference model.
module tb_bus_arbiter;
  localparam int MH = 16;
  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic       to;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic busy, timeout;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  exp_t me;
  int m_owner = -1;
  int m_held = 0;
  int m_ptr = 0;
  bus_arbiter #(.N_REQ(4), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Reference: a tenure ends when its owner stops requesting or after MH grant cycles;
  // the next owner is the first requester found scanning upward from the slot after the last owner.
  task automatic step_push();
    exp_t e;
    e.to = 1'b0;
    if (m_owner >= 0) begin
      if (!req[m_owner] || m_held == MH) begin
        e.to = req[m_owner];
        m_ptr = (m_owner + 1) % 4;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else begin
      for (int k = 0; k < 4; k++)
        if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_held = 1;
        end
    end
    e.g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    e.id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    q.push_back(e);
  endtask
  task automatic cyc(input logic [3:0] r);
    @(negedge clk);
    req = r;
    step_push();
  endtask
  task automatic run(input logic [3:0] r, input int n);
    repeat (n) cyc(r);
  endtask
  task automatic do_reset(input logic [3:0] rel);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 0);
    chk("async_rst_id", 32'(gnt_id), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_timeout", 32'(timeout), 0);
    q.delete();
    m_owner = -1;
    m_held = 0;
    m_ptr = 0;
    req = rel;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step_push();
  endtask
  always @(posedge clk) begin
    #1;
    if (reset && q.size() > 0) begin
      me = q.pop_front();
      chk("gnt", 32'(gnt), 32'(me.g));
      chk("gnt_id", 32'(gnt_id), 32'(me.id));
      chk("timeout", 32'(timeout), 32'(me.to));
      chk("busy", 32'(busy), 32'(|me.g));
      chk("onehot0", 32'($onehot0(gnt)), 1);
      chk("id_consistent", 32'(gnt == 4'd0 ? gnt_id == 2'd0 : gnt == 4'(1 << gnt_id)), 1);
    end
  end
  initial begin
    logic [3:0] r;
    #1;
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_id", 32'(gnt_id), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_timeout", 32'(timeout), 0);
    @(negedge clk);
    reset = 1'b1;
    req = 4'b0001;
    step_push();
    run(4'b0001, 40);
    run(4'b0000, 3);
    run(4'b1111, 90);
    run(4'b0000, 3);
    run(4'b0100, 3);
    run(4'b1011, 8);
    run(4'b0011, 4);
    run(4'b0000, 3);
    run(4'b0100, 1);
    run(4'b0000, 4);
    do_reset(4'b0000);
    run(4'b0010, 3);
    do_reset(4'b0110);
    run(4'b0110, 6);
    r = 4'b0000;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom_range(15));
      cyc(r);
      if (n == 400) do_reset(r);
    end
    run(4'b0000, 3);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
